// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with optional transmit FIFO
//
// Optional feature macro: UART_TX_FIFO_EN
//   defined   : FIFO_DEPTH-entry FIFO in front of the shifter, frames chain back to back
//   undefined : single-word path, data_ready only while idle
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   data_in    in   [DATA_BITS] word to transmit
//   data_valid in   word offered on data_in
//   mode       in   [4] baud select (0 4800, 1 9600, 2 115200, 3 256000, 4 921600, else 9600)
//   data_ready out  a word offered this cycle is accepted
//   tx_line    out  serial line, idle high
//   busy       out  frame in progress or words pending
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    input  logic [3:0]           mode,
    output logic                 data_ready,
    output logic                 tx_line,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end

    // Bit periods rounded up so a bit is never shorter than the nominal baud time.
    localparam int DIV_4800   = (CLK_FREQ + 4800 - 1) / 4800;
    localparam int DIV_9600   = (CLK_FREQ + 9600 - 1) / 9600;
    localparam int DIV_115200 = (CLK_FREQ + 115200 - 1) / 115200;
    localparam int DIV_256000 = (CLK_FREQ + 256000 - 1) / 256000;
    localparam int DIV_921600 = (CLK_FREQ + 921600 - 1) / 921600;
    localparam int CNT_W      = $clog2(DIV_4800 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    function automatic logic [CNT_W-1:0] div_for(input logic [3:0] m);
        case (m)
            4'd0:    return CNT_W'(DIV_4800);
            4'd2:    return CNT_W'(DIV_115200);
            4'd3:    return CNT_W'(DIV_256000);
            4'd4:    return CNT_W'(DIV_921600);
            default: return CNT_W'(DIV_9600);
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [CNT_W-1:0]     div_q, div_d;

    logic                 accept;
    logic                 word_avail;
    logic [DATA_BITS-1:0] next_word;
    logic                 pending;
    logic                 take;
    logic                 bit_end;

    assign accept = data_valid && data_ready;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign data_ready = !fifo_full;
    assign pending    = !fifo_empty;
    // An empty FIFO is bypassed so a word accepted while idle starts next cycle.
    assign word_avail = !fifo_empty || accept;
    assign next_word  = fifo_empty ? data_in : mem_q[rd_ptr_q];
    assign pop        = take && !fifo_empty;
    assign push       = accept && !(take && fifo_empty);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end
`else
    assign data_ready = (state_q == IDLE);
    assign pending    = 1'b0;
    assign word_avail = accept;
    assign next_word  = data_in;
`endif

    assign bit_end = (clk_cnt_q == div_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        div_d     = div_q;
        take      = 1'b0;

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (word_avail) take = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (word_avail) take = 1'b1;
                        else            state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a word starts a frame; mode is captured here and held until the next load.
        if (take) begin
            state_d   = START;
            shift_d   = next_word;
            par_d     = (^next_word) ^ (PARITY == 2);
            div_d     = div_for(mode);
            clk_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            div_q     <= CNT_W'(DIV_9600);
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            div_q     <= div_d;
        end
    end

    // Line level decoded from registered state, so reset forces it high immediately.
    always_comb begin
        case (state_q)
            START:   tx_line = 1'b0;
            DATA:    tx_line = shift_q[0];
            PAR:     tx_line = par_q;
            default: tx_line = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE) || pending;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;
    logic       dv  [3];
    logic [3:0] md  [3];
    logic       rdy [3];
    logic       txl [3];
    logic       bsy [3];

    int cf_a  [3] = '{100000000, 1000000, 1000000};
    int db_a  [3] = '{8, 7, 8};
    int par_a [3] = '{0, 1, 2};
    int sb_a  [3] = '{1, 2, 1};

    int checks = 0;
    int errors = 0;

    uart_tx_cfg #(.CLK_FREQ(100000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv[0]), .mode(md[0]),
        .data_ready(rdy[0]), .tx_line(txl[0]), .busy(bsy[0]));
    uart_tx_cfg #(.CLK_FREQ(1000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv[1]), .mode(md[1]),
        .data_ready(rdy[1]), .tx_line(txl[1]), .busy(bsy[1]));
    uart_tx_cfg #(.CLK_FREQ(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .data_in(din2), .data_valid(dv[2]), .mode(md[2]),
        .data_ready(rdy[2]), .tx_line(txl[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int cf, input logic [3:0] m);
        int baud;
        case (m)
            4'd0:    baud = 4800;
            4'd1:    baud = 9600;
            4'd2:    baud = 115200;
            4'd3:    baud = 256000;
            4'd4:    baud = 921600;
            default: baud = 9600;
        endcase
        return (cf + baud - 1) / baud;
    endfunction

    task automatic set_din(input int k, input logic [7:0] w);
        case (k)
            0:       din0 = w;
            1:       din1 = w[6:0];
            default: din2 = w;
        endcase
    endtask

    // Checks one frame cycle by cycle, starting at the negedge after the loading edge.
    task automatic check_frame(input int k, input logic [7:0] word, input logic [3:0] mode,
                               input bit clr_dv, input int chg_at, input logic [3:0] chg_mode,
                               input int junk_at);
        bit   lv [$];
        int   d;
        int   ones;
        int   cyc;
        logic obs;
        d = div_of(cf_a[k], mode);
        lv.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < db_a[k]; i++) begin
            lv.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (par_a[k] == 1) lv.push_back(bit'(ones % 2));
        if (par_a[k] == 2) lv.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < sb_a[k]; i++) lv.push_back(1'b1);
        cyc = 0;
        for (int b = 0; b < lv.size(); b++) begin
            obs = lv[b];
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                if (cyc == 0 && clr_dv) dv[k] = 1'b0;
                if (junk_at >= 0 && cyc == junk_at + 1) dv[k] = 1'b0;
                if (txl[k] !== lv[b] && obs === lv[b]) obs = txl[k];
                if (cyc == 1) chk($sformatf("k%0d_busy_in_frame", k), bsy[k], 1);
                if (cyc == chg_at) md[k] = chg_mode;
                if (cyc == junk_at) begin
                    chk($sformatf("k%0d_ready_low_in_frame", k), rdy[k], 0);
                    set_din(k, ~word);
                    dv[k] = 1'b1;
                end
                cyc++;
            end
            chk($sformatf("k%0d_bit%0d_div%0d", k, b, d), obs, lv[b]);
        end
    endtask

    task automatic idle_check(input int k);
        @(negedge clk);
        chk($sformatf("k%0d_idle_tx", k), txl[k], 1);
        chk($sformatf("k%0d_idle_busy", k), bsy[k], 0);
        chk($sformatf("k%0d_idle_ready", k), rdy[k], 1);
    endtask

    task automatic send(input int k, input logic [7:0] word, input logic [3:0] mode,
                        input int chg_at, input logic [3:0] chg_mode, input int junk_at);
        chk($sformatf("k%0d_ready_before_send", k), rdy[k], 1);
        set_din(k, word);
        md[k] = mode;
        dv[k] = 1'b1;
        check_frame(k, word, mode, 1'b1, chg_at, chg_mode, junk_at);
        idle_check(k);
    endtask

    initial begin
        logic [7:0] w [6];
        logic [7:0] rw;
        logic [3:0] rm;
        int         junk;
        logic       exp_rdy;

`ifdef UART_TX_FIFO_EN
        junk = -1;
`else
        junk = 40;
`endif
        rst  = 1'b1;
        din0 = '0;
        din1 = '0;
        din2 = '0;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0;
            md[k] = 4'd2;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d_reset_tx", k), txl[k], 1);
            chk($sformatf("k%0d_reset_busy", k), bsy[k], 0);
            chk($sformatf("k%0d_reset_ready", k), rdy[k], 1);
        end
        @(negedge clk);
        rst = 1'b0;

        // 8N1 at 115200 from 100 MHz, 0xA5
        send(0, 8'hA5, 4'd2, -1, 4'd0, -1);

        // 7E2 at 9600 and 8O1 parity on 0x07
        send(1, 8'h07, 4'd1, -1, 4'd0, -1);
        send(2, 8'h07, 4'd2, -1, 4'd0, junk);

        // Mode change inside DATA affects only the following frame
        send(2, 8'h3C, 4'd2, 30, 4'd0, -1);
        send(2, 8'hC3, 4'd0, -1, 4'd0, -1);

        // Reset in the middle of DATA, then a complete frame on the first edge after release
        set_din(1, 8'h55);
        md[1] = 4'd1;
        dv[1] = 1'b1;
        @(negedge clk);
        dv[1] = 1'b0;
        repeat (149) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_frame_tx", txl[1], 1);
        chk("rst_mid_frame_ready", rdy[1], 1);
        chk("rst_mid_frame_busy", bsy[1], 0);
        @(negedge clk);
        rst = 1'b0;
        send(1, 8'h2B, 4'd1, -1, 4'd0, -1);

        // Five consecutive offers during a frame
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        set_din(2, w[0]);
        md[2] = 4'd2;
        dv[2] = 1'b1;
        fork
            begin
                check_frame(2, w[0], 4'd2, 1'b1, -1, 4'd0, -1);
`ifdef UART_TX_FIFO_EN
                for (int i = 1; i < 5; i++) check_frame(2, w[i], 4'd2, 1'b0, -1, 4'd0, -1);
`endif
            end
            begin
                repeat (3) @(negedge clk);
                for (int i = 1; i <= 5; i++) begin
`ifdef UART_TX_FIFO_EN
                    exp_rdy = (i < 5);
`else
                    exp_rdy = 1'b0;
`endif
                    chk($sformatf("burst_ready_%0d", i), rdy[2], 32'(exp_rdy));
                    set_din(2, w[i]);
                    dv[2] = 1'b1;
                    @(negedge clk);
                end
                dv[2] = 1'b0;
            end
        join
        idle_check(2);

        // Random words and modes
        for (int n = 0; n < 6; n++) begin
            rw = 8'($urandom);
            rm = 4'($urandom_range(0, 15));
            send(1, rw, rm, -1, 4'd0, -1);
            rw = 8'($urandom);
            rm = 4'($urandom_range(0, 15));
            send(2, rw, rm, -1, 4'd0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
